// File: rtl/act_requant_buffer_pkg.sv
// Shared types and defaults for the dense-layer activation requantization buffer.
// The node stage uses the same widths, so they live here rather than in the buffer.
package act_requant_buffer_pkg;

  localparam int NODES_DEF = 200;
  localparam int IN_W_DEF  = 16;
  localparam int OUT_W_DEF = 8;
  localparam int SHIFT_DEF = 4;

  typedef logic signed [IN_W_DEF-1:0] acc_t;
  typedef logic        [OUT_W_DEF-1:0] act_t;

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_e;

  localparam logic [15:0] SAT_CNT_MAX = 16'hFFFF;

  // Saturation-event counter increment that sticks at its maximum.
  function automatic logic [15:0] sat_inc(input logic [15:0] cnt, input logic inc);
    if (inc && (cnt != SAT_CNT_MAX)) begin
      return cnt + 16'd1;
    end else begin
      return cnt;
    end
  endfunction

endpackage

// File: rtl/act_requant_buffer_if.sv
// Node-result input and activation output stream of the requantization buffer.
// master = surrounding logic (node stage + consumer), slave = the buffer itself.
interface act_requant_buffer_if #(
  parameter int NODES = 200,
  parameter int IN_W  = 16,
  parameter int OUT_W = 8,
  parameter int IDX_W = $clog2(NODES)
);
  logic                   valid_in;
  logic signed [IN_W-1:0] x;
  logic                   in_ready;
  logic                   out_valid;
  logic                   out_ready;
  logic [OUT_W-1:0]       out_data;
  logic [IDX_W-1:0]       out_idx;
  logic                   out_last;
  logic                   layer_done;
  logic [15:0]            sat_cnt;

  modport master (
    output valid_in, x, out_ready,
    input  in_ready, out_valid, out_data, out_idx, out_last, layer_done, sat_cnt
  );

  modport slave (
    input  valid_in, x, out_ready,
    output in_ready, out_valid, out_data, out_idx, out_last, layer_done, sat_cnt
  );
endinterface

// File: rtl/act_requant_buffer_requant.sv
// ReLU, round-half-up arithmetic right shift and unsigned saturation of one accumulator.
// Purely combinational so it can be unit-tested on its own.
module requant_relu #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 8,
  parameter int SHIFT = 4
) (
  input  logic signed [IN_W-1:0] x,
  output logic [OUT_W-1:0]       y,
  output logic                   sat
);

  localparam int             RND_SH = (SHIFT > 0) ? (SHIFT - 1) : 0;
  localparam logic [IN_W:0]  RND    = (SHIFT > 0) ? (IN_W+1)'(1 << RND_SH) : '0;
  localparam logic [IN_W:0]  MAX_Q  = (IN_W+1)'((1 << OUT_W) - 1);

  logic [IN_W:0] w_t;
  logic [IN_W:0] w_q;

  // One extra bit keeps the rounding add from wrapping at the positive extreme.
  always_comb begin
    w_t = {1'b0, x} + RND;
    w_q = w_t >> SHIFT;
    if (x[IN_W-1]) begin
      y   = '0;
      sat = 1'b0;
    end else if (w_q > MAX_Q) begin
      y   = MAX_Q[OUT_W-1:0];
      sat = 1'b1;
    end else begin
      y   = w_q[OUT_W-1:0];
      sat = 1'b0;
    end
  end

endmodule

// File: rtl/act_requant_buffer.sv
// Collects one requantized activation per node, then drains the layer in node order.
// Fill and drain never overlap; a two-state FSM alternates between them.
module act_requant_buffer
  import act_requant_buffer_pkg::*;
#(
  parameter int NODES = NODES_DEF,
  parameter int IN_W  = IN_W_DEF,
  parameter int OUT_W = OUT_W_DEF,
  parameter int SHIFT = SHIFT_DEF,
  parameter int IDX_W = $clog2(NODES)
) (
  input  logic                clk,
  input  logic                rst,
  act_requant_buffer_if.slave bus
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NODES - 1);

  state_e             r_state, w_state_nxt;
  logic [IDX_W-1:0]   r_wr_idx, w_wr_idx_nxt;
  logic [IDX_W-1:0]   r_rd_idx, w_rd_idx_nxt;
  logic [IDX_W-1:0]   w_rd_inc;
  logic               r_out_valid, w_out_valid_nxt;
  logic [OUT_W-1:0]   r_out_data, w_out_data_nxt;
  logic               r_out_last, w_out_last_nxt;
  logic               r_layer_done, w_layer_done_nxt;
  logic [15:0]        r_sat_cnt, w_sat_cnt_nxt;
  logic               w_we;
  logic [OUT_W-1:0]   w_y;
  logic               w_sat;
  logic [OUT_W-1:0]   r_buf [NODES];

  requant_relu #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W),
    .SHIFT (SHIFT)
  ) u_requant (
    .x   (bus.x),
    .y   (w_y),
    .sat (w_sat)
  );

  assign w_rd_inc = r_rd_idx + IDX_W'(1);

  // Next-state and next-output logic; outputs are preloaded so they are registered.
  always_comb begin
    w_state_nxt      = r_state;
    w_wr_idx_nxt     = r_wr_idx;
    w_rd_idx_nxt     = r_rd_idx;
    w_out_valid_nxt  = r_out_valid;
    w_out_data_nxt   = r_out_data;
    w_out_last_nxt   = r_out_last;
    w_layer_done_nxt = 1'b0;
    w_sat_cnt_nxt    = r_sat_cnt;
    w_we             = 1'b0;
    case (r_state)
      FILL: begin
        if (bus.valid_in) begin
          w_we          = 1'b1;
          w_sat_cnt_nxt = sat_inc(r_sat_cnt, w_sat);
          if (r_wr_idx == LAST_IDX) begin
            // Entry 0 was written at least one cycle earlier, so it can be preloaded now.
            w_wr_idx_nxt    = '0;
            w_rd_idx_nxt    = '0;
            w_state_nxt     = DRAIN;
            w_out_valid_nxt = 1'b1;
            w_out_data_nxt  = r_buf[0];
            w_out_last_nxt  = 1'b0;
          end else begin
            w_wr_idx_nxt = r_wr_idx + IDX_W'(1);
          end
        end else begin
          w_we = 1'b0;
        end
      end
      DRAIN: begin
        if (bus.out_ready) begin
          if (r_rd_idx == LAST_IDX) begin
            w_rd_idx_nxt     = '0;
            w_state_nxt      = FILL;
            w_out_valid_nxt  = 1'b0;
            w_out_last_nxt   = 1'b0;
            w_layer_done_nxt = 1'b1;
            w_sat_cnt_nxt    = '0;
          end else begin
            w_rd_idx_nxt   = w_rd_inc;
            w_out_data_nxt = r_buf[w_rd_inc];
            w_out_last_nxt = (w_rd_inc == LAST_IDX);
          end
        end else begin
          w_rd_idx_nxt = r_rd_idx;
        end
      end
      default: begin
        w_state_nxt     = FILL;
        w_out_valid_nxt = 1'b0;
      end
    endcase
  end

  // State, index and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= FILL;
      r_wr_idx     <= '0;
      r_rd_idx     <= '0;
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_last   <= 1'b0;
      r_layer_done <= 1'b0;
      r_sat_cnt    <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_wr_idx     <= w_wr_idx_nxt;
      r_rd_idx     <= w_rd_idx_nxt;
      r_out_valid  <= w_out_valid_nxt;
      r_out_data   <= w_out_data_nxt;
      r_out_last   <= w_out_last_nxt;
      r_layer_done <= w_layer_done_nxt;
      r_sat_cnt    <= w_sat_cnt_nxt;
    end
  end

  // Activation storage; contents survive reset and are simply overwritten by the next fill.
  always_ff @(posedge clk) begin
    if (w_we) begin
      r_buf[r_wr_idx] <= w_y;
    end
  end

  assign bus.in_ready   = (r_state == FILL);
  assign bus.out_valid  = r_out_valid;
  assign bus.out_data   = r_out_data;
  assign bus.out_idx    = r_rd_idx;
  assign bus.out_last   = r_out_last;
  assign bus.layer_done = r_layer_done;
  assign bus.sat_cnt    = r_sat_cnt;

endmodule

// File: tb/tb_act_requant_buffer.sv
// Directed bench for act_requant_buffer (NODES=4, SHIFT=4) plus a SHIFT=0 requant unit.
module tb_act_requant_buffer;
  import act_requant_buffer_pkg::*;

  localparam int NODES = 4;
  localparam int IN_W  = 16;
  localparam int OUT_W = 8;
  localparam int SHIFT = 4;
  localparam int IDX_W = 2;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  logic [7:0] exp_d [NODES];

  act_requant_buffer_if #(.NODES(NODES), .IN_W(IN_W), .OUT_W(OUT_W), .IDX_W(IDX_W)) bus ();

  act_requant_buffer #(
    .NODES (NODES),
    .IN_W  (IN_W),
    .OUT_W (OUT_W),
    .SHIFT (SHIFT),
    .IDX_W (IDX_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  acc_t rq_x;
  act_t rq_y;
  logic rq_sat;

  requant_relu #(.IN_W(16), .OUT_W(8), .SHIFT(0)) u_rq0 (
    .x   (rq_x),
    .y   (rq_y),
    .sat (rq_sat)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input logic [15:0] v0, input logic [15:0] v1,
                      input logic [15:0] v2, input logic [15:0] v3);
    logic [15:0] v [4];
    v = '{v0, v1, v2, v3};
    for (int i = 0; i < 4; i++) begin
      check("fill_in_ready", 32'(bus.in_ready), 32'd1);
      check("fill_out_valid", 32'(bus.out_valid), 32'd0);
      bus.valid_in = 1'b1;
      bus.x        = v[i];
      step();
    end
    bus.valid_in = 1'b0;
    bus.x        = '0;
    check("drain_entry_in_ready", 32'(bus.in_ready), 32'd0);
  endtask

  // mode 0: out_ready always 1; mode 1: out_ready pattern 1,0,0,1 repeating
  task automatic drain(input int mode, input int exp_sat, input int nbeats);
    int   beat;
    int   cyc;
    logic rdy;
    beat = 0;
    cyc  = 0;
    while (beat < nbeats && cyc < 200) begin
      rdy = (mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
      check("drain_out_valid", 32'(bus.out_valid), 32'd1);
      check("drain_in_ready", 32'(bus.in_ready), 32'd0);
      check("drain_out_idx", 32'(bus.out_idx), 32'(beat));
      check("drain_out_data", 32'(bus.out_data), 32'(exp_d[beat]));
      check("drain_out_last", 32'(bus.out_last), (beat == NODES - 1) ? 32'd1 : 32'd0);
      check("drain_sat_cnt", 32'(bus.sat_cnt), 32'(exp_sat));
      check("drain_layer_done", 32'(bus.layer_done), 32'd0);
      bus.out_ready = rdy;
      step();
      cyc++;
      if (rdy) beat++;
    end
    bus.out_ready = 1'b0;
    check("drain_beats_within_budget", 32'(beat), 32'(nbeats));
    if (nbeats == NODES) begin
      check("done_layer_done", 32'(bus.layer_done), 32'd1);
      check("done_sat_cnt_clear", 32'(bus.sat_cnt), 32'd0);
      check("done_out_valid", 32'(bus.out_valid), 32'd0);
      check("done_in_ready", 32'(bus.in_ready), 32'd1);
      step();
      check("done_pulse_width", 32'(bus.layer_done), 32'd0);
    end
  endtask

  initial begin
    rst           = 1'b1;
    bus.valid_in  = 1'b0;
    bus.x         = '0;
    bus.out_ready = 1'b0;
    rq_x          = '0;
    step();
    step();
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_layer_done", 32'(bus.layer_done), 32'd0);
    check("rst_sat_cnt", 32'(bus.sat_cnt), 32'd0);
    check("rst_out_data", 32'(bus.out_data), 32'd0);
    check("rst_out_idx", 32'(bus.out_idx), 32'd0);
    check("rst_out_last", 32'(bus.out_last), 32'd0);
    rst = 1'b0;
    step();

    // basic layer: 256->16, 23->1, -5->0, 8->1
    fill(16'h0100, 16'h0017, 16'hFFFB, 16'h0008);
    exp_d = '{8'd16, 8'd1, 8'd0, 8'd1};
    drain(0, 0, 4);

    // saturation plus drain lockout: valid_in held during DRAIN must be ignored
    fill(16'h0FF8, 16'h7FFF, 16'h0010, 16'h0007);
    check("sat_cnt_after_fill", 32'(bus.sat_cnt), 32'd2);
    bus.valid_in = 1'b1;
    bus.x        = 16'h0100;
    for (int i = 0; i < 3; i++) begin
      step();
      check("lockout_in_ready", 32'(bus.in_ready), 32'd0);
      check("lockout_out_data", 32'(bus.out_data), 32'd255);
      check("lockout_out_idx", 32'(bus.out_idx), 32'd0);
    end
    bus.valid_in = 1'b0;
    bus.x        = '0;
    exp_d = '{8'd255, 8'd255, 8'd1, 8'd0};
    drain(0, 2, 4);

    // backpressure; also shows the next layer starts writing at index 0
    fill(16'h0040, 16'h0107, 16'h0018, 16'h0FE7);
    exp_d = '{8'd4, 8'd16, 8'd2, 8'd254};
    drain(1, 0, 4);

    // reset after two drained beats
    fill(16'h0100, 16'h0200, 16'h0030, 16'h0000);
    exp_d = '{8'd16, 8'd32, 8'd3, 8'd0};
    drain(0, 0, 2);
    rst = 1'b1;
    #1;
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    check("midrst_out_idx", 32'(bus.out_idx), 32'd0);
    check("midrst_out_last", 32'(bus.out_last), 32'd0);
    step();
    rst = 1'b0;
    fill(16'h0020, 16'h0011, 16'h8000, 16'h0FF7);
    exp_d = '{8'd2, 8'd1, 8'd0, 8'd255};
    drain(0, 0, 4);

    // SHIFT=0 requant: no rounding offset
    rq_x = 16'sd200;
    #1;
    check("rq0_200_y", 32'(rq_y), 32'd200);
    check("rq0_200_sat", 32'(rq_sat), 32'd0);
    rq_x = 16'sd300;
    #1;
    check("rq0_300_y", 32'(rq_y), 32'd255);
    check("rq0_300_sat", 32'(rq_sat), 32'd1);
    rq_x = -16'sd1;
    #1;
    check("rq0_neg_y", 32'(rq_y), 32'd0);
    check("rq0_neg_sat", 32'(rq_sat), 32'd0);
    rq_x = 16'sd255;
    #1;
    check("rq0_255_y", 32'(rq_y), 32'd255);
    check("rq0_255_sat", 32'(rq_sat), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/act_requant_buffer.md
Name: act_requant_buffer

Overview:
- Stage directly downstream of the dense-layer node compute block.
- Consumes one signed accumulator result per node, applies ReLU, then round-half-up right shift, then unsigned saturation to 8 bits.
- Collects a full layer of NODES activations in a buffer, then drains them in node order over a valid/ready stream.
- That stream feeds the next layer's prev_outputs loader.

Parameters:
- NODES, 200, activations per layer (buffer depth); must be ≥ 2.
- IN_W, 16, signed accumulator input width.
- OUT_W, 8, unsigned activation output width.
- SHIFT, 4, requantization right-shift amount, 0..IN_W-1.
- IDX_W, $clog2(NODES), width of the node index fields.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- valid_in  input  1  x carries a new node result this cycle.
- x  input  IN_W  signed accumulator value from the node stage.
- in_ready  output  1  buffer is accepting results (high only in FILL).
- out_valid  output  1  out_data/out_idx hold a valid activation.
- out_ready  input  1  consumer accepts the current activation.
- out_data  output  OUT_W  requantized activation.
- out_idx  output  IDX_W  node index of out_data.
- out_last  output  1  current beat is node NODES-1.
- layer_done  output  1  one-cycle pulse after the last beat transfers.
- sat_cnt  output  16  saturation events in the current layer; the counter itself saturates at 0xFFFF.

Behaviour:
- Reset (async, any state, including mid-fill or mid-drain):
  - state=FILL, wr_idx=0, rd_idx=0.
  - out_valid=0, layer_done=0, sat_cnt=0, in_ready=1.
  - out_data=0, out_idx=0, out_last=0.
  - Buffer contents are not reset; a partial layer is discarded.
- Requant (combinational, per accepted x):
  - neg = x<0 → y=0 (ReLU).
  - Otherwise t = x + (SHIFT>0 ? 2^(SHIFT-1) : 0), computed in IN_W+1 bits so it cannot overflow; y = t >> SHIFT.
  - If y > 2^OUT_W-1, output 2^OUT_W-1 and flag sat=1.
- FILL state:
  - in_ready=1, out_valid=0.
  - Accept on valid_in: buf[wr_idx] ← requant(x); sat_cnt += sat (saturating).
  - wr_idx increments each accept; one write per cycle; back-to-back accepts are allowed.
  - Accept with wr_idx==NODES-1: wr_idx←0, next state DRAIN.
  - Write latency: the value is in the buffer one cycle after acceptance.
- DRAIN state:
  - in_ready=0; valid_in is ignored (upstream must hold off; no error flag).
  - out_valid=1 from the first DRAIN cycle.
  - out_data = buf[rd_idx], out_idx = rd_idx, out_last = (rd_idx==NODES-1).
  - Transfer occurs when out_valid && out_ready; rd_idx increments.
  - With out_ready=0, all outputs hold stable.
  - Transfer with out_last=1:
    - rd_idx←0, state←FILL.
    - layer_done=1 for exactly the next cycle.
    - sat_cnt clears to 0 in that same cycle, so it is readable throughout DRAIN.
  - in_ready rises the cycle after the last transfer.
- Throughput: NODES fill cycles plus NODES drain cycles minimum; fill and drain never overlap.
- State encoding: 2-state FSM, FILL and DRAIN only.

Decomposition:
- dense_pkg:
  - NODES, IN_W, OUT_W defaults shared with the node stage.
  - Typedef acc_t (signed IN_W) and act_t (unsigned OUT_W).
  - State enum {FILL, DRAIN}.
- One natural sub-module: requant_relu.
  - Purely combinational; parameters IN_W, OUT_W, SHIFT.
  - Ports x → y, sat.
  - Unit-testable on its own.
- Top holds the FSM, counters, buffer array (distributed RAM, combinational read) and sat counter.

Test Plan:
- Basic layer (NODES=4, SHIFT=4): send x=0x0100, 0x0017, -5, 0x0008 back-to-back → drained out_data 16, 1, 0, 1 with out_idx 0..3, out_last only on idx 3, layer_done one cycle after, sat_cnt=0.
- Saturation: send x=0x0FF8 ((4088+8)>>4=256) and 0x7FFF → out_data 255 both; sat_cnt=2 throughout DRAIN, 0 after layer_done.
- Backpressure: drain with out_ready toggling 1,0,0,1,… → each idx delivered exactly once, in order, with outputs stable while out_ready=0.
- Drain lockout: assert valid_in with x=0x0100 during DRAIN → in_ready=0, buffer unchanged, drained values match the prior fill; next layer starts at wr_idx 0.
- Reset mid-operation: assert rst after 2 beats drained → out_valid=0, in_ready=1 immediately; a fresh 4-value layer drains correctly from idx 0.
- SHIFT=0 build: x=200, 300, -1 → 200, 255 (sat), 0; no rounding offset applied.
